inv_sub_bytes_iter: RTL

- Iterative AES InvSubBytes stage for the decryption datapath. It applies the FIPS-197 inverse S-box to all 16 bytes of a 128-bit state.
- Processes LANES bytes per cycle using LANES inverse S-box lookups, so a block costs 16/LANES cycles of datapath.
- Sits between InvShiftRows and AddRoundKey in the inverse cipher round.
- Uses a valid/ready handshake on both input and output so the round controller can stall it.

---
 rtl/inv_sub_bytes_iter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes stage.
// Substitutes LANES bytes of a 128-bit state per cycle through the inverse S-box.
// It uses a valid/ready handshake on both the input and the output side.
// Optional macro INV_SUB_BYTES_FWD_EN adds a fwd_mode input. When it is set,
// the forward S-box is used instead, so one unit serves both directions.
module inv_sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] state_out,
  output logic         busy
`ifdef INV_SUB_BYTES_FWD_EN
  ,
  input  logic         fwd_mode
`endif
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  // Table rows are stored MSB-first, so entry b sits at bits [8b +: 8].
  localparam logic [0:2047] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_TBL[int'(b) * 8 +: 8];
  endfunction

`ifdef INV_SUB_BYTES_FWD_EN
  localparam logic [0:2047] FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb8145ede0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
    return FWD_TBL[int'(b) * 8 +: 8];
  endfunction
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] STEP     = 4'(LANES);
  localparam logic [3:0] LAST_IDX = 4'(16 - LANES);

  state_t       state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [0:127] work_q, work_d;
  logic [0:127] out_q, out_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;
  logic         mode_q, mode_d;

  logic [6:0]   lane_pos [LANES];
  logic [7:0]   lane_out [LANES];

  // One S-box lookup per lane; lane j serves byte idx+j of the work register.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign lane_pos[j] = {idx_q, 3'b000} + 7'(8 * j);
`ifdef INV_SUB_BYTES_FWD_EN
    assign lane_out[j] = mode_q ? fwd_sbox(work_q[lane_pos[j] +: 8])
                                : inv_sbox(work_q[lane_pos[j] +: 8]);
`else
    assign lane_out[j] = inv_sbox(work_q[lane_pos[j] +: 8]);
`endif
  end

  // Next-state logic for the FSM, the byte counter and the work/output registers.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    work_d  = work_q;
    out_d   = out_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = state_in;
          idx_d   = 4'd0;
          state_d = BUSY;
`ifdef INV_SUB_BYTES_FWD_EN
          mode_d  = fwd_mode;
`endif
        end
      end
      BUSY: begin
        for (int j = 0; j < LANES; j++) begin
          work_d[lane_pos[j] +: 8] = lane_out[j];
        end
        idx_d = idx_q + STEP;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          out_d   = work_d;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // All state and registered outputs; reset discards any in-flight block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      work_q      <= '0;
      out_q       <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      work_q      <= work_d;
      out_q       <= out_d;
      mode_q      <= mode_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign state_out = out_q;

endmodule
